// File: rtl/pipeline_dmem_responder.sv
// Data-memory responder for the MEM stage: big-endian byte/half/word storage
// answering each accepted access a fixed LATENCY cycles later.
module pipeline_dmem_responder #(
  parameter int ADDR_WORDS_LOG2 = 8,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  input  logic [1:0]  dataSize,
  input  logic        reqSigned,
  output logic        stall,
  output logic        respValid,
  output logic [31:0] respRData,
  output logic        respError
);

  localparam int DEPTH = 1 << ADDR_WORDS_LOG2;
  localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                     state_r;
  logic [2:0]                 count_r;
  logic [ADDR_WORDS_LOG2-1:0] idx_r;
  logic [1:0]                 offset_r;
  logic [1:0]                 size_r;
  logic                       loadSigned_r;
  logic                       isWrite_r;
  logic                       isError_r;
  logic                       respValid_r;
  logic [31:0]                respRData_r;
  logic                       respError_r;

  logic [31:0] mem [DEPTH];

  logic                       accept_s;
  logic                       enterResp_s;
  logic                       reqError_s;
  logic [ADDR_WORDS_LOG2-1:0] reqIdx_s;
  logic [ADDR_WORDS_LOG2-1:0] curIdx_s;
  logic [1:0]                 curOffset_s;
  logic [1:0]                 curSize_s;
  logic                       curSigned_s;
  logic                       curWrite_s;
  logic                       curError_s;
  logic [31:0]                loadValue_s;
  logic                       memWrite_s;
  logic [3:0]                 wrMask_s;
  logic [31:0]                wrData_s;
  logic [31-(ADDR_WORDS_LOG2+2):0] unusedAddrBits_s;

  // Halfwords need even addresses, words need 4-byte alignment, size 11 is reserved.
  function automatic logic accessError(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = off[0];
      2'b10:   err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Mask bit 3 is lane [31:24], which holds byte offset 0 (big-endian).
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b1000 >> off;
      2'b01:   m = off[1] ? 4'b0011 : 4'b1100;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   r = {{24{sext & b[7]}}, b};
      2'b01:   r = {{16{sext & h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign reqIdx_s         = reqAddr[ADDR_WORDS_LOG2+1:2];
  assign unusedAddrBits_s = reqAddr[31:ADDR_WORDS_LOG2+2];

  assign stall     = ((state_r == ST_IDLE) && reqValid) || (state_r == ST_WAIT);
  assign respValid = respValid_r;
  assign respRData = respRData_r;
  assign respError = respError_r;

  // Request decode; with LATENCY=1 the response is built from the live request fields.
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && reqValid;
    reqError_s = accessError(dataSize, reqAddr[1:0]);
    if (state_r == ST_IDLE) begin
      curIdx_s    = reqIdx_s;
      curOffset_s = reqAddr[1:0];
      curSize_s   = dataSize;
      curSigned_s = reqSigned;
      curWrite_s  = reqWrite;
      curError_s  = reqError_s;
    end else begin
      curIdx_s    = idx_r;
      curOffset_s = offset_r;
      curSize_s   = size_r;
      curSigned_s = loadSigned_r;
      curWrite_s  = isWrite_r;
      curError_s  = isError_r;
    end
    if (accept_s && (LATENCY == 1)) begin
      enterResp_s = 1'b1;
    end else if ((state_r == ST_WAIT) && (count_r == 3'd0)) begin
      enterResp_s = 1'b1;
    end else begin
      enterResp_s = 1'b0;
    end
    if (curWrite_s || curError_s) begin
      loadValue_s = 32'h0000_0000;
    end else begin
      loadValue_s = extractLoad(mem[curIdx_s], curSize_s, curOffset_s, curSigned_s);
    end
    memWrite_s = accept_s && reqWrite && !reqError_s && !reset;
    wrMask_s   = laneMask(dataSize, reqAddr[1:0]);
    wrData_s   = laneData(dataSize, reqWData);
  end

  // Storage: legal stores commit their byte lanes on the acceptance edge; never reset.
  always_ff @(posedge clk) begin
    if (memWrite_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wrMask_s[i]) begin
          mem[reqIdx_s][8*i +: 8] <= wrData_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with latched request fields and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      count_r      <= 3'd0;
      idx_r        <= '0;
      offset_r     <= 2'b00;
      size_r       <= 2'b00;
      loadSigned_r <= 1'b0;
      isWrite_r    <= 1'b0;
      isError_r    <= 1'b0;
      respValid_r  <= 1'b0;
      respRData_r  <= 32'h0000_0000;
      respError_r  <= 1'b0;
    end else begin
      respValid_r <= enterResp_s;
      respRData_r <= enterResp_s ? loadValue_s : 32'h0000_0000;
      respError_r <= enterResp_s ? curError_s : 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (reqValid) begin
            idx_r        <= reqIdx_s;
            offset_r     <= reqAddr[1:0];
            size_r       <= dataSize;
            loadSigned_r <= reqSigned;
            isWrite_r    <= reqWrite;
            isError_r    <= reqError_s;
            if (LATENCY == 1) begin
              state_r <= ST_RESP;
            end else begin
              state_r <= ST_WAIT;
              count_r <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (count_r == 3'd0) begin
            state_r <= ST_RESP;
          end else begin
            count_r <= count_r - 3'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_dmem_responder.sv
// Bench for pipeline_dmem_responder: three instances (LATENCY 2, 1, 7) checked
// against a byte-addressed big-endian memory model plus fixed vector tables.
module tb_pipeline_dmem_responder;

  logic clk;
  logic reset;
  logic [2:0]       reqValidV, reqWriteV, reqSignedV, stallV, respValidV, respErrorV;
  logic [2:0][31:0] reqAddrV, reqWDataV, respRDataV;
  logic [2:0][1:0]  dataSizeV;

  int passCnt  = 0;
  int totalCnt = 0;

  byte unsigned mb [3][1024];

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    bit          sgn;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  vec_t vecs [19];

  for (genvar g = 0; g < 3; g++) begin : gDut
    pipeline_dmem_responder #(
      .ADDR_WORDS_LOG2(8),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 7))
    ) uDut (
      .clk(clk),
      .reset(reset),
      .reqValid(reqValidV[g]),
      .reqWrite(reqWriteV[g]),
      .reqAddr(reqAddrV[g]),
      .reqWData(reqWDataV[g]),
      .dataSize(dataSizeV[g]),
      .reqSigned(reqSignedV[g]),
      .stall(stallV[g]),
      .respValid(respValidV[g]),
      .respRData(respRDataV[g]),
      .respError(respErrorV[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int latOf(input int id);
    return (id == 0) ? 2 : ((id == 1) ? 1 : 7);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Reference model: a 1 KiB byte array (1024 bytes wrap), most significant byte at the lowest address.
  function automatic void modelAccess(input int id, input bit w, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [1:0] sz, input bit sgn,
                                      output logic [31:0] rd, output bit err);
    int a;
    int n;
    longint v;
    a   = int'(addr % 32'd1024);
    n   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    err = (sz == 2'd3) || ((a % n) != 0);
    rd  = 32'h0;
    if (!err && w) begin
      for (int i = 0; i < n; i++) mb[id][a+i] = 8'(wdata >> (8 * (n - 1 - i)));
    end else if (!err) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v * 256 + longint'(mb[id][a+i]);
      if (sgn && (v >= (longint'(1) << (8 * n - 1)))) v = v - (longint'(1) << (8 * n));
      rd = 32'(v);
    end
  endfunction

  task automatic doAccess(input int id, input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] sz, input bit sgn, input bit useExp,
                          input logic [31:0] tExp, input bit tErr);
    logic [31:0] mData;
    bit          mErr;
    logic [31:0] eData;
    bit          eErr;
    int          k;
    bit          got;
    string       tag;
    modelAccess(id, w, addr, wdata, sz, sgn, mData, mErr);
    eData = useExp ? tExp : mData;
    eErr  = useExp ? tErr : mErr;
    tag   = $sformatf("i%0d %s@%08h", id, w ? "st" : "ld", addr);
    @(negedge clk);
    reqValidV[id]  = 1'b1;
    reqWriteV[id]  = w;
    reqAddrV[id]   = addr;
    reqWDataV[id]  = wdata;
    dataSizeV[id]  = sz;
    reqSignedV[id] = sgn;
    #1;
    check({tag, " stall-request"}, 64'(stallV[id]), 64'd1);
    got = 1'b0;
    k   = 0;
    while (!got && (k < 12)) begin
      @(posedge clk);
      #1;
      k++;
      if (respValidV[id]) got = 1'b1;
      else check({tag, " wait-state"}, 64'({stallV[id], respErrorV[id], respRDataV[id]}),
                 64'({1'b1, 1'b0, 32'h0}));
    end
    check({tag, " latency"}, 64'(k), 64'(latOf(id)));
    if (got) begin
      check({tag, " rdata"}, 64'(respRDataV[id]), 64'(eData));
      check({tag, " error"}, 64'(respErrorV[id]), 64'(eErr));
      check({tag, " stall-resp"}, 64'(stallV[id]), 64'd0);
    end
    @(negedge clk);
    reqValidV[id] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " single-pulse"}, 64'({respValidV[id], respErrorV[id], respRDataV[id]}), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 2'd2, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h23,  32'h0,        2'd0, 1'b1, 32'h00000044, 1'b0};
    vecs[4]  = '{1'b1, 32'h21,  32'h00000080, 2'd0, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h21,  32'h0,        2'd0, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[6]  = '{1'b0, 32'h20,  32'h0,        2'd1, 1'b0, 32'h00001180, 1'b0};
    vecs[7]  = '{1'b1, 32'h22,  32'h0000BEEF, 2'd1, 1'b0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h22,  32'h0,        2'd1, 1'b1, 32'hFFFFBEEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h22,  32'h0,        2'd0, 1'b0, 32'h000000BE, 1'b0};
    vecs[10] = '{1'b1, 32'h30,  32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h32,  32'hAAAAAAAA, 2'd2, 1'b0, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h30,  32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 32'h30,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1};
    vecs[14] = '{1'b1, 32'h30,  32'h55555555, 2'd3, 1'b0, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 32'h31,  32'h0,        2'd1, 1'b1, 32'h0,        1'b1};
    vecs[16] = '{1'b0, 32'h30,  32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[17] = '{1'b1, 32'h400, 32'h12345678, 2'd2, 1'b0, 32'h0,        1'b0};
    vecs[18] = '{1'b0, 32'h000, 32'h0,        2'd2, 1'b0, 32'h12345678, 1'b0};

    reset      = 1'b1;
    reqValidV  = '0;
    reqWriteV  = '0;
    reqSignedV = '0;
    reqAddrV   = '0;
    reqWDataV  = '0;
    dataSizeV  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++)
      check($sformatf("i%0d reset-state", id),
            64'({stallV[id], respValidV[id], respErrorV[id], respRDataV[id]}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++)
      check($sformatf("i%0d after-reset", id),
            64'({stallV[id], respValidV[id], respErrorV[id], respRDataV[id]}), 64'd0);

    // Give every word a known value so the model covers all of storage.
    for (int id = 0; id < 3; id++)
      for (int wi = 0; wi < 256; wi++)
        doAccess(id, 1'b1, 32'(wi * 4), $urandom, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 19; i++)
      doAccess(0, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].sz, vecs[i].sgn,
               1'b1, vecs[i].expData, vecs[i].expErr);

    // Reset while a load of 0x10 sits in WAIT: it must vanish without a response.
    @(negedge clk);
    reqValidV[0] = 1'b1; reqWriteV[0] = 1'b0; reqAddrV[0] = 32'h10;
    dataSizeV[0] = 2'd2; reqSignedV[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; reqValidV[0] = 1'b0;
    @(posedge clk);
    #1;
    check("reset-in-wait idle", 64'({stallV[0], respValidV[0], respErrorV[0], respRDataV[0]}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset-in-wait no-resp", 64'({stallV[0], respValidV[0]}), 64'd0);

    // A store presented during reset must not commit.
    @(negedge clk);
    reset = 1'b1; reqValidV[0] = 1'b1; reqWriteV[0] = 1'b1; reqAddrV[0] = 32'h10;
    reqWDataV[0] = 32'h0BADF00D; dataSizeV[0] = 2'd2;
    @(posedge clk);
    #1;
    check("reset-priority no-resp", 64'(respValidV[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0; reqValidV[0] = 1'b0;
    @(posedge clk);
    #1;
    check("reset-priority idle", 64'({stallV[0], respValidV[0]}), 64'd0);
    doAccess(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Randomized back-to-back traffic on all three latencies.
    for (int id = 0; id < 3; id++) begin
      for (int n = 0; n < ((id == 0) ? 200 : 80); n++) begin
        s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 2047));
        if ($urandom_range(0, 3) != 0) begin
          if (s == 2'd1) a[0] = 1'b0;
          if (s == 2'd2) a[1:0] = 2'b00;
        end
        doAccess(id, 1'($urandom_range(0, 1)), a, $urandom, s, 1'($urandom_range(0, 1)),
                 1'b0, 32'h0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/pipeline_dmem_responder.md
PIPELINE_DMEM_RESPONDER -- requirements
Module: pipeline_dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WORDS_LOG2, default 8, giving log2 of storage depth in 32-bit words (256 words).
REQ-002 SHALL have parameter LATENCY, default 2, giving cycles from request to response; legal range 1..7.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port reqValid  input  1  MEM stage presents an access this cycle.
REQ-006 SHALL have port reqWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port reqAddr  input  32  byte address.
REQ-008 SHALL have port reqWData  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port dataSize  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 SHALL have port reqSigned  input  1  load sign-extends when 1, zero-extends when 0.
REQ-011 SHALL have port stall  output  1  holds the pipeline while an access is outstanding.
REQ-012 SHALL have port respValid  output  1  one-cycle pulse marking completion.
REQ-013 SHALL have port respRData  output  32  load result, valid while respValid=1.
REQ-014 SHALL have port respError  output  1  misaligned or reserved-size access, valid while respValid=1.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL accept a request only in IDLE with reqValid=1, latching all request fields on that edge.
REQ-017 SHALL ignore reqValid in WAIT and RESP; the requester holds its fields stable via stall.
REQ-018 SHALL on acceptance go to RESP when LATENCY=1, else to WAIT with a down-counter loaded with LATENCY-2.
REQ-019 SHALL leave WAIT for RESP when the counter is 0, and decrement it otherwise.
REQ-020 SHALL spend exactly one cycle in RESP, then return to IDLE.
REQ-021 SHALL drive respValid=1 only in RESP, so the response appears exactly LATENCY cycles after the request cycle.
REQ-022 SHALL drive stall combinationally as (IDLE and reqValid) or WAIT; stall SHALL be 0 in RESP.
REQ-023 SHALL use word index reqAddr[ADDR_WORDS_LOG2+1:2] and silently ignore the upper address bits (wrap-around).
REQ-024 SHALL order bytes big-endian: byte offset 0 maps to bits [31:24], offset 3 maps to [7:0].
REQ-025 SHALL treat an access as misaligned when a halfword has addr[0]=1 or a word has addr[1:0]!=0.
REQ-026 SHALL treat dataSize=11 as an error, handled the same as a misaligned access.
REQ-027 SHALL commit a legal store on the acceptance edge, writing only the addressed byte lanes.
REQ-028 SHALL complete a store with respValid=1, respRData=0 and respError=0.
REQ-029 SHALL register load data on the edge entering RESP, selecting the addressed lanes and then extending per reqSigned.
REQ-030 SHALL have any load accepted after a store observe that store's data.
REQ-031 SHALL for an erroneous access leave storage unmodified and drive respError=1, respRData=0, with the same timing as a legal access.
REQ-032 SHALL drive respRData=0 and respError=0 whenever respValid=0.

Reset
REQ-033 SHALL on reset=1 force IDLE, clear the counter, clear respRData and respError, and discard any pending access.
REQ-034 SHALL give stall=0 and respValid=0 in the first cycle after reset.
REQ-035 SHALL not clear storage contents on reset.
REQ-036 SHALL let reset take priority over a simultaneous reqValid, so no store commits in a reset cycle.

Verification
REQ-037 Word store then load, LATENCY=2: store 0xDEADBEEF to 0x10, then load word 0x10; each access gives stall=1 for 2 cycles, respValid in cycle 2, and the load returns 0xDEADBEEF.
REQ-038 Byte/half lanes: word 0x11223344 at 0x20; signed byte load at 0x23 -> 0x00000044; store byte 0x80 at 0x21 then signed byte load 0x21 -> 0xFFFFFF80; unsigned half load 0x20 -> 0x00001180.
REQ-039 Misalignment: word store 0xAAAAAAAA to 0x32 -> respError=1, and a word load at 0x30 returns its prior value unchanged; dataSize=11 -> respError=1.
REQ-040 Wrap-around, ADDR_WORDS_LOG2=8: store 0x12345678 to 0x400, then load 0x000 -> 0x12345678.
REQ-041 Reset mid-operation: assert reset during WAIT -> next cycle IDLE, respValid stays 0, stall=0, storage intact.
REQ-042 LATENCY=1 and LATENCY=7 sweep: back-to-back requests get respValid exactly LATENCY cycles after each request cycle, with no lost or duplicated responses.
